// File: rtl/cpu_pkg.sv
// cpu_pkg: CPU-wide widths, masks and the data memory FSM state type.
package cpu_pkg;

    localparam int REG_LEN       = 32;
    localparam int DM_UNIT_MASK  = 255;
    localparam int DM_MASK       = 511;
    localparam int IM_MASK       = 255;
    localparam int L1_INDEX_MASK = 31;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dm_state_t;

endpackage

// File: rtl/data_memory.sv
// data_memory: line-wide main memory behind the L1 data cache, answering one
// request at a time with a fixed latency and a single-cycle ack.
module data_memory
    import cpu_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = DM_MASK + 1,
    parameter int ADDR_W  = REG_LEN,
    parameter int LINE_W  = DM_UNIT_MASK + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LAST  = 4'(LATENCY - 1);

    logic [LINE_W-1:0] memory [0:DEPTH-1];
    dm_state_t         state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx;
    logic              unused_addr;

    // Request fields are sampled live; the requester holds them until the ack edge.
    assign idx         = addr_i[5 +: IDX_W];
    assign unused_addr = ^{addr_i[ADDR_W-1:5+IDX_W], addr_i[4:0]};
    assign ack_o       = state == BUSY && cnt == LAST;
    assign data_o      = ack_o ? memory[idx] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            state <= enable_i ? BUSY : IDLE;
            cnt   <= '0;
        end else if (ack_o) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + 4'd1;
        end
    end

    // Storage has no reset; a reset on the ack edge still suppresses the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && ack_o && write_i) memory[idx] <= data_i;
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed checks of latency, ack shape, writes, aliasing,
// reset abort and back-to-back handshakes of data_memory.
module tb_data_memory;
    import cpu_pkg::*;

    localparam logic [255:0] A5 = {32{8'hA5}};
    localparam logic [255:0] FF = {32{8'hFF}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr = '0;
    logic [255:0] data = '0;
    logic         enable = 1'b0;
    logic         write = 1'b0;
    logic         ack;
    logic [255:0] data_out;

    int checks = 0;
    int errors = 0;

    data_memory dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data),
        .enable_i(enable), .write_i(write), .ack_o(ack), .data_o(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One request; returns ack data and the cycle (1 = first cycle after acceptance) of the ack.
    task automatic txn(input logic [31:0] a, input logic [255:0] d, input logic w,
                       output logic [255:0] q, output int cyc);
        @(negedge clk);
        addr = a; data = d; write = w; enable = 1'b1;
        @(posedge clk);
        cyc = 0;
        q = '0;
        for (int i = 1; i <= 40 && cyc == 0; i++) begin
            @(negedge clk);
            enable = 1'b0;
            if (ack) begin
                cyc = i;
                q = data_out;
            end else if (i <= 2) begin
                check("idle_data_zero", data_out, '0);
            end
        end
        if (cyc == 0) check("ack_timeout", 256'(cyc), 256'(10));
        @(negedge clk);
        check("ack_one_cycle", 256'(ack), 256'(0));
        check("post_ack_data_zero", data_out, '0);
    endtask

    logic [255:0] q;
    int cyc, acks, last, first;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ack", 256'(ack), 256'(0));
        check("reset_data", data_out, '0);
        check("reset_state", 256'(dut.state), 256'(IDLE));
        rst = 1'b0;

        // Preload through the bus so bench and DUT never both drive the array.
        txn(32'h0, 256'h5, 1'b1, q, cyc);
        check("wr_latency", 256'(cyc), 256'(10));
        txn(32'h20, 256'h11, 1'b1, q, cyc);
        txn(32'h420, 256'h33, 1'b1, q, cyc);
        check("pre_mem0", dut.memory[0], 256'h5);

        txn(32'h0, '0, 1'b0, q, cyc);
        check("rd0_latency", 256'(cyc), 256'(10));
        check("rd0_data", q, 256'h5);

        txn(32'h400, A5, 1'b1, q, cyc);
        check("wr400_mem32", dut.memory[32], A5);
        txn(32'h41F, '0, 1'b0, q, cyc);
        check("rd41f_data", q, A5);
        check("mem33_kept", dut.memory[33], 256'h33);

        txn(32'h4000, '0, 1'b0, q, cyc);
        check("alias_hi_data", q, 256'h5);

        // Reset at cnt=5 of a write aborts it.
        @(negedge clk);
        addr = 32'h20; data = FF; write = 1'b1; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_cnt", 256'(dut.cnt), 256'(5));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 256'(dut.state), 256'(IDLE));
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("abort_no_ack", 256'(acks), 256'(0));
        check("abort_mem1", dut.memory[1], 256'h11);
        txn(32'h20, '0, 1'b0, q, cyc);
        check("after_abort_latency", 256'(cyc), 256'(10));
        check("after_abort_data", q, 256'h11);

        // Enable held high: alternating reads of line 0 and line 1.
        @(negedge clk);
        addr = 32'h0; write = 1'b0; enable = 1'b1;
        acks = 0;
        last = -100;
        for (int c = 0; c < 80 && acks < 4; c++) begin
            @(negedge clk);
            if (ack) begin
                check("b2b_data", data_out, (acks % 2 == 0) ? 256'h5 : 256'h11);
                if (acks > 0) check("b2b_gap", 256'(c - last), 256'(11));
                last = c;
                acks++;
                if (acks == 4) enable = 1'b0;
            end else if (c == last + 1) begin
                addr = (acks % 2 == 1) ? 32'h20 : 32'h0;
            end
        end
        check("b2b_count", 256'(acks), 256'(4));
        repeat (3) @(negedge clk);

        // Enable toggled while busy starts nothing extra.
        @(negedge clk);
        addr = 32'h0; write = 1'b0; enable = 1'b1;
        @(posedge clk);
        acks = 0;
        first = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                if (first == 0) first = c;
                enable = 1'b0;
            end else if (acks == 0) begin
                enable = ~enable;
            end
        end
        check("toggle_acks", 256'(acks), 256'(1));
        check("toggle_latency", 256'(first), 256'(10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
